// File: rtl/mul_client_pkg.sv
// Shared types for the TDM multiplier client port: FSM state encoding and
// the width of the fractional-shift field.
package mul_client_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Shift field is wide enough to express a shift of the full product width.
  function automatic int shift_w(input int dw);
    return $clog2(2 * dw) + 1;
  endfunction

endpackage

// File: rtl/mul_client_port_shift.sv
// Combinational post-multiply stage: arithmetic right shift of the product,
// then either saturation (MUL_CLIENT_SAT_EN defined) or plain truncation.
module mul_shift_sat #(
  parameter int data_width = 16,
  parameter int shift_w    = 6
)(
  input  logic [2*data_width-1:0] prod,
  input  logic [shift_w-1:0]      shift,
  output logic [data_width-1:0]   data,
  output logic                    overflow
);

  localparam int W = data_width;

  logic signed [2*W-1:0] shifted;

  // Shift amounts at or beyond the product width fill with the sign bit.
  assign shifted = $signed(prod) >>> shift;

`ifdef MUL_CLIENT_SAT_EN
  logic fits;

  // Value fits when every bit above the result sign bit matches it.
  assign fits = (&shifted[2*W-1:W-1]) | ~(|shifted[2*W-1:W-1]);

  // Clamp out-of-range values toward the sign of the full result.
  always_comb begin
    data     = shifted[W-1:0];
    overflow = 1'b0;
    if (!fits) begin
      overflow = 1'b1;
      data     = shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^shifted[2*W-1:W];
  assign data      = shifted[W-1:0];
  assign overflow  = 1'b0;
`endif

endmodule

// File: rtl/mul_client_port.sv
// Requester-side endpoint of the TDM shared multiplier. Presents one operand
// pair on this slot, ignores the done pulse that lands in the arming cycle
// (it belongs to the previous operands), captures the next product, and
// returns the shifted result over valid/ready. Optional saturation is built
// when MUL_CLIENT_SAT_EN is defined.
module mul_client_port
  import mul_client_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_blocks   = 2,
  parameter int timeout    = n_blocks + 4,
  localparam int SHIFT_W   = shift_w(data_width),
  localparam int CTR_W     = $clog2(timeout + 1)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [data_width-1:0]   in_a,
  input  logic [data_width-1:0]   in_b,
  input  logic [SHIFT_W-1:0]      in_shift,
  output logic [data_width-1:0]   mul_req_a,
  output logic [data_width-1:0]   mul_req_b,
  input  logic [2*data_width-1:0] mul_result,
  input  logic                    mul_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_width-1:0]   out_data,
  output logic                    overflow,
  output logic                    timeout_err
);

  state_t                state, state_nxt;
  logic [SHIFT_W-1:0]    shift_q;
  logic [CTR_W-1:0]      wait_ctr;
  logic [data_width-1:0] shaped;
  logic                  shaped_ovf;
  logic                  timed_out;

  mul_shift_sat #(
    .data_width (data_width),
    .shift_w    (SHIFT_W)
  ) u_shift (
    .prod     (mul_result),
    .shift    (shift_q),
    .data     (shaped),
    .overflow (shaped_ovf)
  );

  // Final wait cycle with no done: give up on this request.
  assign timed_out = (state == S_WAIT) && !mul_done &&
                     (wait_ctr == CTR_W'(timeout - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)  state_nxt = S_ARM;
      S_ARM:                 state_nxt = S_WAIT;
      S_WAIT: if (mul_done)  state_nxt = S_OUT;
              else if (timed_out) state_nxt = S_IDLE;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
  end

  // Operand capture, wait counter, result capture and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mul_req_a   <= '0;
      mul_req_b   <= '0;
      shift_q     <= '0;
      wait_ctr    <= '0;
      out_data    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        mul_req_a <= in_a;
        mul_req_b <= in_b;
        shift_q   <= in_shift;
      end
      wait_ctr <= (state == S_WAIT) ? wait_ctr + CTR_W'(1) : '0;
      if (state == S_WAIT && mul_done) begin
        out_data <= shaped;
        overflow <= shaped_ovf;
      end
      if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_client_port.sv
// Scoreboard bench for mul_client_port (dw=16, n_blocks=4, client at slot 2
// of a 4-slot rotation). Main process issues requests and pushes expected
// results; a monitor compares each newly presented result.
module tb_mul_client_port;

  localparam int DW = 16;
  localparam int NB = 4;
  localparam int SW = 6;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [SW-1:0] in_shift = '0;
  logic [DW-1:0] mul_req_a, mul_req_b;
  logic [2*DW-1:0] mul_result;
  logic          mul_done;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          overflow;
  logic          timeout_err;

  logic          rot_en = 1'b0, rot_done = 1'b0, man_done = 1'b0;
  logic [2*DW-1:0] rot_result = '0, man_result = '0;
  int            cyc = 0;
  int            checks = 0, errors = 0;
  exp_t          q[$];

  assign mul_done   = rot_done | man_done;
  assign mul_result = man_done ? man_result : rot_result;

  mul_client_port #(.data_width(DW), .n_blocks(NB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_shift(in_shift),
    .mul_req_a(mul_req_a), .mul_req_b(mul_req_b),
    .mul_result(mul_result), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Rotating shared multiplier: this client's slot completes every NB cycles.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rot_done   = rot_en && (cyc % NB == 2);
      rot_result = $signed(mul_req_a) * $signed(mul_req_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each result as it is first presented.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_data %h with no request outstanding", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("overflow", 32'(overflow), 32'(e.ovf));
        end
      end
      prev = out_valid;
    end
  end

  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SW-1:0] sh, input logic [DW-1:0] ed, input logic eo);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_shift = sh; in_valid = 1'b1;
    q.push_back('{data: ed, ovf: eo});
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    wait_valid(k);
    chk("latency_in_range", 32'((k - 1) >= 2 && (k - 1) <= NB + 2), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_cleared", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int k;
    logic quiet;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_req_a", 32'(mul_req_a), 32'd0);
    chk("rst_req_b", 32'(mul_req_b), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    rot_en = 1'b1;

    // 1: Q15-style scale
    run_req(16'h4000, 16'h2000, 6'd15, 16'h1000, 1'b0);
    // 2: full-scale square, saturating vs wrapping
`ifdef MUL_CLIENT_SAT_EN
    run_req(16'h7FFF, 16'h7FFF, 6'd0, 16'h7FFF, 1'b1);
`else
    run_req(16'h7FFF, 16'h7FFF, 6'd0, 16'h0001, 1'b0);
`endif
    // Shift boundaries: beyond product width gives sign fill
    run_req(16'h8000, 16'h0001, 6'd40, 16'hFFFF, 1'b0);
    run_req(16'h1234, 16'h0001, 6'd63, 16'h0000, 1'b0);
    run_req(16'hFFFE, 16'h0003, 6'd0, 16'hFFFA, 1'b0);

    // 4: back-pressure with a second request pending
    @(negedge clk);
    in_a = 16'h0010; in_b = 16'h0020; in_shift = 6'd4; in_valid = 1'b1;
    q.push_back('{data: 16'h0020, ovf: 1'b0});
    @(negedge clk);
    in_a = 16'hFFFE; in_b = 16'h0003; in_shift = 6'd0;
    q.push_back('{data: 16'hFFFA, ovf: 1'b0});
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'h0020);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(in_ready), 32'd0);
    chk("bp_second_req_a", 32'(mul_req_a), 32'h0000FFFE);
    wait_valid(k);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // 3: stale done during arming cycle is ignored
    rot_en = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    in_a = 16'd3; in_b = 16'd5; in_shift = 6'd0; in_valid = 1'b1;
    q.push_back('{data: 16'd15, ovf: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    man_done = 1'b1; man_result = 32'h00001234;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("arm_done_ignored", 32'(out_valid), 32'd0);
    man_done = 1'b1; man_result = 32'd15;
    @(negedge clk);
    man_done = 1'b0;
    chk("wait_done_taken", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // 5: reset while waiting discards the request
    @(negedge clk);
    in_a = 16'h0100; in_b = 16'h0200; in_shift = 6'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rstb_out_valid", 32'(out_valid), 32'd0);
    chk("rstb_req_a", 32'(mul_req_a), 32'd0);
    chk("rstb_req_b", 32'(mul_req_b), 32'd0);
    chk("rstb_in_ready", 32'(in_ready), 32'd1);
    man_done = 1'b1; man_result = 32'h00020000;
    @(negedge clk);
    man_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) quiet = 1'b0;
      @(negedge clk);
    end
    chk("rstb_no_output", 32'(quiet), 32'd1);

    // 6: missing done raises sticky timeout_err
    @(negedge clk);
    in_a = 16'd1; in_b = 16'd1; in_shift = 6'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("timeout_not_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("timeout_set", 32'(timeout_err), 32'd1);
    chk("timeout_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
